// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared widths, FSM state type and the 32-tap droop-compensation
// coefficient set used by cic_comp_fir and its testbench.
//
// Coefficients are signed Q1.17 and mirror-symmetric. Their signed sum is
// exactly 2^17 (131072), which gives unity DC gain. Their absolute sum is
// 236992, which is greater than 2^17, so a sign-matched full-scale input can
// overflow the 16-bit output range.
package cic_comp_pkg;

  localparam int COEF_W = 18;
  localparam int TAPS   = 32;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam coef_t COEF [0:TAPS-1] = '{
    -18'sd80,     18'sd120,    18'sd240,   -18'sd200,
    -18'sd600,    18'sd150,    18'sd1400,   18'sd600,
    -18'sd2600,  -18'sd2400,   18'sd4200,   18'sd6000,
    -18'sd5600,  -18'sd15000,  18'sd9000,   18'sd70306,
     18'sd70306,  18'sd9000,  -18'sd15000, -18'sd5600,
     18'sd6000,   18'sd4200,  -18'sd2400,  -18'sd2600,
     18'sd600,    18'sd1400,   18'sd150,   -18'sd600,
    -18'sd200,    18'sd240,    18'sd120,   -18'sd80
  };

endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: registered signed multiply-accumulate with synchronous clear
// and enable. Clear takes priority over enable.
module cic_comp_mac #(
  parameter int IN_W   = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 39
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [IN_W-1:0]   sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [IN_W+COEF_W-1:0] product;

  assign product = sample * coef;

  // Accumulator register: cleared at the start of each run, adds one product per enabled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(product);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimate-by-2 CIC droop-compensation FIR. Every second
// accepted sample triggers a TAPS-cycle multiply-accumulate over the sample
// history, followed by round-half-up and narrowing to OUT_W bits.
//
// Optional feature macro: CIC_COMP_FIR_SAT_EN
//   defined   -> the rounded result saturates to the OUT_W range and out_sat
//                flags the clip
//   undefined -> the rounded result wraps (two's complement) and out_sat is 0
module cic_comp_fir #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int COEF_W = cic_comp_pkg::COEF_W,
  parameter int TAPS   = cic_comp_pkg::TAPS,
  parameter int ACC_W  = IN_W + COEF_W + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  input  logic                    out_ready,
  output logic                    out_sat
);

  import cic_comp_pkg::*;

  localparam int PW = $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_W - 2);

  state_t                   state;
  logic [PW-1:0]            wp;
  logic [PW-1:0]            k;
  logic [PW-1:0]            rd_idx;
  logic                     phase;
  logic                     accept;
  logic                     mac_clear;
  logic                     mac_en;
  logic signed [IN_W-1:0]   sample_buf [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  narrow;
  logic                     clip;

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = (state == IDLE) && in_valid;
  assign mac_clear = accept && phase;
  assign mac_en    = (state == MAC);

  // The newest sample sits just behind the write pointer; tap k reaches k samples further back
  assign rd_idx = wp - PW'(1) - k;

  cic_comp_mac #(
    .IN_W   (IN_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (mac_en),
    .sample (sample_buf[rd_idx]),
    .coef   (COEF[k]),
    .acc    (acc)
  );

  // Round half up, then drop the Q1.17 coefficient fraction bits
  assign shifted = (acc + HALF) >>> (COEF_W - 1);

`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) <<< (OUT_W - 1));

  // Clamp the rounded value to the representable output range and flag any clip
  always_comb begin
    narrow = OUT_W'(shifted);
    clip   = 1'b0;
    if (shifted > MAX_V) begin
      narrow = {1'b0, {(OUT_W-1){1'b1}}};
      clip   = 1'b1;
    end else if (shifted < MIN_V) begin
      narrow = {1'b1, {(OUT_W-1){1'b0}}};
      clip   = 1'b1;
    end
  end
`else
  assign narrow = OUT_W'(shifted);
  assign clip   = 1'b0;
`endif

  // Sample history: written on every accepted input, fully cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        sample_buf[i] <= '0;
      end
    end else if (accept) begin
      sample_buf[wp] <= in_data;
    end
  end

  // Control FSM: input acceptance and decimation phase, MAC sequencing, rounding and output hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wp        <= '0;
      k         <= '0;
      phase     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wp    <= wp + PW'(1);
            phase <= ~phase;
            if (phase) begin
              k     <= '0;
              state <= MAC;
            end
          end
        end
        MAC: begin
          k <= k + PW'(1);
          if (k == PW'(TAPS - 1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_data  <= narrow;
          out_sat   <= clip;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: randomized self-checking bench for cic_comp_fir with a
// direct-convolution reference model over the full accepted-input history.
`timescale 1ns/1ps
module tb_cic_comp_fir;

  import cic_comp_pkg::*;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int CLK_P = 10;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
    int                      trig;
  } exp_t;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
  } log_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready = 1'b0;
  logic                    out_sat;

  int   hist [$];
  exp_t expq [$];
  log_t out_log [$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfer   = 0;
  int   cyc      = 0;
  int   ready_mode = 0;
  logic prev_valid = 1'b0;

  // Hand-computed impulse responses: round(COEF[2n+1]/8)
  logic signed [OUT_W-1:0] imp_exp [16] = '{
    16'sh000F, 16'shFFE7, 16'sh0013, 16'sh004B,   //   15,  -25,   19,   75
    16'shFED4, 16'sh02EE, 16'shF8AD, 16'sh2254,   // -300,  750,-1875, 8788
    16'sh0465, 16'shFD44, 16'sh020D, 16'shFEBB,   // 1125, -700,  525, -325
    16'sh00AF, 16'shFFB5, 16'sh001E, 16'shFFF6    //  175,  -75,   30,  -10
  };

  cic_comp_fir dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  always #(CLK_P/2) clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Reference: y = sum_k COEF[k] * x[n-1-k], round half up, then wrap or clamp
  function automatic exp_t model_out(input int trig);
    longint acc = 0;
    longint r;
    int     n = hist.size();
    exp_t   e;
    for (int t = 0; t < TAPS; t++) begin
      if (n - 1 - t >= 0) acc += longint'(COEF[t]) * longint'(hist[n-1-t]);
    end
    r = (acc + 65536) >>> 17;
    e.sat  = 1'b0;
    e.trig = trig;
`ifdef CIC_COMP_FIR_SAT_EN
    if (r > 32767) begin
      r = 32767;
      e.sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.sat = 1'b1;
    end
`endif
    e.data = 16'(r);
    return e;
  endfunction

  // Scoreboard: record accepted inputs, predict outputs, retire completed transfers
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      expq.delete();
    end else begin
      cyc++;
      if (out_valid && out_ready) begin
        out_log.push_back('{out_data, out_sat});
        n_xfer++;
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (in_valid && in_ready) begin
        hist.push_back(int'(in_data));
        if (hist.size() % 2 == 0) expq.push_back(model_out(cyc));
      end
    end
  end

  // Compare process: every cycle out_valid is high the output must match the model
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checkOutput("spurious_out_valid", 1, 0);
        end else begin
          checkOutput("out_data", out_data, expq[0].data);
          checkOutput("out_sat", out_sat, expq[0].sat);
          checkOutput("in_ready_in_hold", in_ready, 0);
          if (!prev_valid) checkOutput("latency", cyc - expq[0].trig, TAPS + 1);
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Downstream ready: always, random, or held off
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic applyReset();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_sat", out_sat, 0);
    @(negedge clk);
    out_log.delete();
  endtask

  task automatic applyStimulus(input logic signed [IN_W-1:0] x, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((expq.size() != 0 || out_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_done", longint'(expq.size() == 0 && !out_valid), 1);
  endtask

  initial begin
    #(90000 * CLK_P);
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int xfer0;

    $display("[TB] start");
    ready_mode = 0;
    applyReset();

    // Impulse response
    applyStimulus(16'sh4000, 0);
    for (int i = 0; i < 63; i++) applyStimulus(16'sh0000, 0);
    drain();
    checkOutput("impulse_count", out_log.size(), 32);
    for (int i = 0; i < 32 && i < out_log.size(); i++) begin
      if (i < 16) checkOutput($sformatf("impulse_%0d", i), out_log[i].data, imp_exp[i]);
      else        checkOutput($sformatf("impulse_tail_%0d", i), out_log[i].data, 0);
    end

    // DC gain
    applyReset();
    for (int i = 0; i < 64; i++) applyStimulus(16'sh2000, 0);
    drain();
    checkOutput("dc_count", out_log.size(), 32);
    for (int i = 15; i < out_log.size(); i++) begin
      checkOutput($sformatf("dc_%0d", i), out_log[i].data, 16'sh2000);
      checkOutput($sformatf("dc_sat_%0d", i), out_log[i].sat, 0);
    end

    // Sign-matched full-scale input
    applyReset();
    for (int m = 0; m < TAPS; m++) begin
      applyStimulus((COEF[TAPS-1-m] >= 0) ? 16'sh7FFF : 16'sh8000, 0);
    end
    drain();
    checkOutput("sat_count", out_log.size(), 16);
    if (out_log.size() >= 16) begin
`ifdef CIC_COMP_FIR_SAT_EN
      checkOutput("sat_data", out_log[15].data, 16'sh7FFF);
      checkOutput("sat_flag", out_log[15].sat, 1);
`else
      checkOutput("wrap_data", out_log[15].data, 16'shE76F);
      checkOutput("wrap_flag", out_log[15].sat, 0);
`endif
    end

    // Backpressure
    ready_mode = 2;
    applyStimulus(16'($urandom), 0);
    applyStimulus(16'($urandom), 0);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", out_valid, 1);
      checkOutput("bp_in_ready_low", in_ready, 0);
    end
    xfer0 = n_xfer;
    ready_mode = 0;
    repeat (5) @(negedge clk);
    checkOutput("bp_one_transfer", n_xfer - xfer0, 1);
    checkOutput("bp_valid_dropped", out_valid, 0);
    applyStimulus(16'($urandom), 0);
    applyStimulus(16'($urandom), 0);
    drain();

    // Reset in the middle of a MAC run
    applyReset();
    applyStimulus(16'sh1234, 0);
    applyStimulus(16'sh7000, 0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("midmac_in_ready", in_ready, 0);
    checkOutput("midmac_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midmac_release_in_ready", in_ready, 1);
    xfer0 = n_xfer;
    repeat (50) @(negedge clk);
    checkOutput("midmac_no_output", n_xfer - xfer0, 0);
    out_log.delete();
    applyStimulus(16'sh4000, 0);
    applyStimulus(16'sh4000, 0);
    drain();
    checkOutput("midmac_count", out_log.size(), 1);
    if (out_log.size() >= 1) checkOutput("midmac_data", out_log[0].data, 5);

    // Long random stream across many write-pointer wraps
    ready_mode = 1;
    out_log.delete();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 2)));
    end
    drain();
    checkOutput("random_count", out_log.size(), 500);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
